// File: rtl/pe_dot_sequencer_if.sv
// rtl/pe_dot_sequencer_if.sv - handshake and PE-side signal bundle for pe_dot_sequencer
// Ports (grouped): command (cmd_valid/cmd_len/cmd_ready), operand stream
// (in_valid/in_floatA/in_floatB/in_ready), PE drive (pe_clear/pe_floatA/pe_floatB/pe_result),
// result (out_valid/out_result/out_ready), status (busy).
// master = environment side, slave = sequencer side.
interface pe_dot_sequencer_if #(
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_ready;
    logic             in_valid;
    logic [15:0]      in_floatA;
    logic [15:0]      in_floatB;
    logic             in_ready;
    logic             pe_clear;
    logic [15:0]      pe_floatA;
    logic [15:0]      pe_floatB;
    logic [15:0]      pe_result;
    logic             out_valid;
    logic [15:0]      out_result;
    logic             out_ready;
    logic             busy;

    modport master (
        output cmd_valid, cmd_len,
        input  cmd_ready,
        output in_valid, in_floatA, in_floatB,
        input  in_ready,
        input  pe_clear, pe_floatA, pe_floatB,
        output pe_result,
        input  out_valid, out_result,
        output out_ready,
        input  busy
    );

    modport slave (
        input  cmd_valid, cmd_len,
        output cmd_ready,
        input  in_valid, in_floatA, in_floatB,
        output in_ready,
        output pe_clear, pe_floatA, pe_floatB,
        input  pe_result,
        output out_valid, out_result,
        input  out_ready,
        output busy
    );
endinterface

// File: rtl/pe_dot_sequencer.sv
// rtl/pe_dot_sequencer.sv - sequences one PE through a half-precision dot product
// Ports: clk, reset (sync, active-high), bus (pe_dot_sequencer_if.slave) carrying the
// command, operand stream, PE drive, result handshake and busy status.
module pe_dot_sequencer #(
    parameter int LEN_W = 8
) (
    input logic              clk,
    input logic              reset,
    pe_dot_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic             drain_cnt;
    logic             pe_clear_q;
    logic [15:0]      a_q;
    logic [15:0]      b_q;
    logic [15:0]      out_result_q;
    logic             cmd_ready_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    // Status flags are registered alongside every state transition so they
    // always match the state register without a decode stage on the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            remaining    <= '0;
            drain_cnt    <= 1'b0;
            pe_clear_q   <= 1'b1;   // PE clears at the edge after reset
            a_q          <= 16'h0000;
            b_q          <= 16'h0000;
            out_result_q <= 16'h0000;
            cmd_ready_q  <= 1'b1;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // Zero operands by default: a stalled or idle PE accumulates 0.
            pe_clear_q <= 1'b0;
            a_q        <= 16'h0000;
            b_q        <= 16'h0000;
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        remaining   <= bus.cmd_len;
                        pe_clear_q  <= 1'b1;
                        state       <= S_CLEAR;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    drain_cnt <= 1'b0;
                    if (remaining != '0) begin
                        state      <= S_STREAM;
                        in_ready_q <= 1'b1;
                    end else begin
                        state <= S_DRAIN;
                    end
                end
                S_STREAM: begin
                    if (bus.in_valid) begin
                        a_q <= bus.in_floatA;
                        b_q <= bus.in_floatB;
                        if (remaining != '0) begin
                            remaining <= remaining - LEN_W'(1);
                        end
                        if (remaining == LEN_W'(1)) begin
                            state      <= S_DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    // Two cycles: the last pair is multiplied in the first and
                    // its sum is visible on pe_result in the second.
                    drain_cnt <= ~drain_cnt;
                    if (drain_cnt) begin
                        out_result_q <= bus.pe_result;
                        state        <= S_DONE;
                        out_valid_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state       <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.in_ready   = in_ready_q;
    assign bus.pe_clear   = pe_clear_q;
    assign bus.pe_floatA  = a_q;
    assign bus.pe_floatB  = b_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.busy       = busy_q;
endmodule
